// File: rtl/rf_writeback_queue.sv
// rf_writeback_queue: write-side front end of the register file.
// Accepts load and ALU results (load has priority) into a small FIFO and
// issues at most one registered RF write per cycle. The core can look up
// queued or in-flight writes for two read addresses to forward their data.
module rf_writeback_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          wb_hold,
  output logic [AW-1:0] dst_addr,
  output logic [DW-1:0] dst_data,
  output logic          reg_write,
  input  logic [AW-1:0] src_addr,
  input  logic [AW-1:0] tar_addr,
  output logic          src_hit,
  output logic [DW-1:0] src_fwd,
  output logic          tar_hit,
  output logic [DW-1:0] tar_fwd,
  output logic          full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] dst_addr_q, dst_addr_d;
  logic [DW-1:0] dst_data_q, dst_data_d;
  logic          reg_write_q, reg_write_d;

  logic [AW-1:0] mem_addr_q [DEPTH];
  logic [DW-1:0] mem_data_q [DEPTH];

  logic          push_fire;
  logic          enq;
  logic          pop;
  logic [AW-1:0] push_addr;
  logic [DW-1:0] push_data;

  // Storage slot and occupancy of each entry, ordered by age (0 = oldest)
  logic [PW-1:0] age_idx [DEPTH];
  logic          age_vld [DEPTH];

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_idx[gi] = rd_ptr_q + PW'(gi);
      assign age_vld[gi] = (CW'(gi) < count_q);
    end
  endgenerate

  assign full      = (count_q == CW'(DEPTH));
  assign ld_ready  = !full;
  assign alu_ready = !full && !ld_valid;
  assign dst_addr  = dst_addr_q;
  assign dst_data  = dst_data_q;
  assign reg_write = reg_write_q;

  // Push selection and next-state for pointers, count and the output stage
  always_comb begin
    push_fire   = (ld_valid && ld_ready) || (alu_valid && alu_ready);
    push_addr   = ld_valid ? ld_addr : alu_addr;
    push_data   = ld_valid ? ld_data : alu_data;
    // Writes to register 0 complete the handshake but are dropped here
    enq         = push_fire && (push_addr != '0);
    pop         = (count_q != '0) && !wb_hold;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    count_d     = count_q;
    dst_addr_d  = dst_addr_q;
    dst_data_d  = dst_data_q;
    reg_write_d = 1'b0;
    if (enq) begin
      wr_ptr_d = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d    = rd_ptr_q + PW'(1);
      dst_addr_d  = mem_addr_q[rd_ptr_q];
      dst_data_d  = mem_data_q[rd_ptr_q];
      reg_write_d = 1'b1;
    end
    case ({enq, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control and output-stage registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      dst_addr_q  <= '0;
      dst_data_q  <= '0;
      reg_write_q <= 1'b0;
    end else begin
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      dst_addr_q  <= dst_addr_d;
      dst_data_q  <= dst_data_d;
      reg_write_q <= reg_write_d;
    end
  end

  // FIFO payload storage; occupancy is tracked by count, so no reset needed
  always_ff @(posedge clk) begin
    if (enq) begin
      mem_addr_q[wr_ptr_q] <= push_addr;
      mem_data_q[wr_ptr_q] <= push_data;
    end
  end

  // Forwarding lookup: output stage first, then FIFO oldest to youngest so
  // the youngest match overrides
  always_comb begin
    src_hit = 1'b0;
    src_fwd = '0;
    tar_hit = 1'b0;
    tar_fwd = '0;
    if (reg_write_q && (dst_addr_q == src_addr)) begin
      src_hit = 1'b1;
      src_fwd = dst_data_q;
    end
    if (reg_write_q && (dst_addr_q == tar_addr)) begin
      tar_hit = 1'b1;
      tar_fwd = dst_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      if (age_vld[i] && (mem_addr_q[age_idx[i]] == src_addr)) begin
        src_hit = 1'b1;
        src_fwd = mem_data_q[age_idx[i]];
      end
      if (age_vld[i] && (mem_addr_q[age_idx[i]] == tar_addr)) begin
        tar_hit = 1'b1;
        tar_fwd = mem_data_q[age_idx[i]];
      end
    end
    if (src_addr == '0) begin
      src_hit = 1'b0;
      src_fwd = '0;
    end
    if (tar_addr == '0) begin
      tar_hit = 1'b0;
      tar_fwd = '0;
    end
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Bench for rf_writeback_queue: directed scenarios followed by random traffic,
// all compared against a queue-based reference model.
module tb_rf_writeback_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ld_valid = 1'b0;
  logic [AW-1:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_ready;
  logic          alu_valid = 1'b0;
  logic [AW-1:0] alu_addr = '0;
  logic [DW-1:0] alu_data = '0;
  logic          alu_ready;
  logic          wb_hold = 1'b0;
  logic [AW-1:0] dst_addr;
  logic [DW-1:0] dst_data;
  logic          reg_write;
  logic [AW-1:0] src_addr = '0;
  logic [AW-1:0] tar_addr = '0;
  logic          src_hit;
  logic [DW-1:0] src_fwd;
  logic          tar_hit;
  logic [DW-1:0] tar_fwd;
  logic          full;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rf_writeback_queue #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_data(ld_data), .ld_ready(ld_ready),
    .alu_valid(alu_valid), .alu_addr(alu_addr), .alu_data(alu_data), .alu_ready(alu_ready),
    .wb_hold(wb_hold), .dst_addr(dst_addr), .dst_data(dst_data), .reg_write(reg_write),
    .src_addr(src_addr), .tar_addr(tar_addr),
    .src_hit(src_hit), .src_fwd(src_fwd), .tar_hit(tar_hit), .tar_fwd(tar_fwd),
    .full(full)
  );

  // Reference model: pending writes in acceptance order plus the RF write stage
  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  ent_t          mq[$];
  logic          m_out_v = 1'b0;
  logic [AW-1:0] m_out_a = '0;
  logic [DW-1:0] m_out_d = '0;

  function automatic void model_reset();
    mq.delete();
    m_out_v = 1'b0;
    m_out_a = '0;
    m_out_d = '0;
  endfunction

  // Newest pending value for an address; the write stage is the oldest one
  function automatic void model_look(input logic [AW-1:0] a, output logic hit,
                                     output logic [DW-1:0] fwd);
    hit = 1'b0;
    fwd = '0;
    if (a != '0) begin
      if (m_out_v && m_out_a == a) begin
        hit = 1'b1;
        fwd = m_out_d;
      end
      foreach (mq[i]) begin
        if (mq[i].a == a) begin
          hit = 1'b1;
          fwd = mq[i].d;
        end
      end
    end
  endfunction

  // One clock edge of the model, using the inputs present at that edge
  function automatic void model_edge();
    ent_t e;
    bit   mfull;
    mfull = (mq.size() == DEPTH);
    if (mq.size() > 0 && !wb_hold) begin
      e       = mq.pop_front();
      m_out_v = 1'b1;
      m_out_a = e.a;
      m_out_d = e.d;
    end else begin
      m_out_v = 1'b0;
    end
    if (!mfull) begin
      if (ld_valid) begin
        if (ld_addr != '0) begin
          e.a = ld_addr;
          e.d = ld_data;
          mq.push_back(e);
        end
      end else if (alu_valid) begin
        if (alu_addr != '0) begin
          e.a = alu_addr;
          e.d = alu_data;
          mq.push_back(e);
        end
      end
    end
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    logic          eh;
    logic [DW-1:0] ef;
    bit            mfull;
    mfull = (mq.size() == DEPTH);
    chk("full", full, mfull);
    chk("ld_ready", ld_ready, !mfull);
    chk("alu_ready", alu_ready, !mfull && !ld_valid);
    chk("reg_write", reg_write, m_out_v);
    chk("dst_addr", dst_addr, m_out_a);
    chk("dst_data", dst_data, m_out_d);
    model_look(src_addr, eh, ef);
    chk("src_hit", src_hit, eh);
    chk("src_fwd", src_fwd, ef);
    model_look(tar_addr, eh, ef);
    chk("tar_hit", tar_hit, eh);
    chk("tar_fwd", tar_fwd, ef);
  endtask

  // Check current outputs, apply one edge to DUT and model, return at negedge
  task automatic step();
    #1;
    check_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic drive(input logic lv, input logic [AW-1:0] la, input logic [DW-1:0] ldd,
                       input logic av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                       input logic h);
    ld_valid  = lv;
    ld_addr   = la;
    ld_data   = ldd;
    alu_valid = av;
    alu_addr  = aa;
    alu_data  = ad;
    wb_hold   = h;
  endtask

  task automatic idle(input logic h);
    drive(1'b0, '0, '0, 1'b0, '0, '0, h);
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    #1 check_all();
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset release checked");

    // ALU write to r5: visible for lookup after the push edge, written one edge later
    src_addr = 5;
    drive(1'b0, '0, '0, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
    step();
    idle(1'b0);
    #1;
    chk("t2_hit", src_hit, 1'b1);
    chk("t2_fwd", src_fwd, 32'hDEADBEEF);
    chk("t2_nowrite", reg_write, 1'b0);
    step();
    #1;
    chk("t2_write", reg_write, 1'b1);
    chk("t2_dst", dst_addr, 5);
    repeat (2) step();
    $display("alu single write checked");

    // Load and ALU together: load wins, ALU waits one edge
    drive(1'b1, 5'd3, 32'd1, 1'b1, 5'd4, 32'd2, 1'b0);
    #1;
    chk("t3_ldr", ld_ready, 1'b1);
    chk("t3_alur", alu_ready, 1'b0);
    step();
    drive(1'b0, '0, '0, 1'b1, 5'd4, 32'd2, 1'b0);
    step();
    idle(1'b0);
    #1 chk("t3_first", dst_addr, 3);
    step();
    #1 chk("t3_second", dst_addr, 4);
    repeat (2) step();
    $display("load priority checked");

    // Fill under hold, fifth push refused, then drain in order
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, AW'(8 + i), 32'h100 + 32'(i), 1'b0, '0, '0, 1'b1);
      step();
    end
    idle(1'b1);
    #1 chk("t4_full", full, 1'b1);
    idle(1'b0);
    repeat (6) step();
    $display("fill and drain checked");

    // Two queued writes to r7: newest value is forwarded on both ports
    src_addr = 7;
    tar_addr = 7;
    drive(1'b1, 5'd7, 32'd1, 1'b0, '0, '0, 1'b1);
    step();
    drive(1'b1, 5'd7, 32'd2, 1'b0, '0, '0, 1'b1);
    step();
    idle(1'b1);
    #1;
    chk("t5_src_fwd", src_fwd, 32'd2);
    chk("t5_tar_fwd", tar_fwd, 32'd2);
    chk("t5_tar_hit", tar_hit, 1'b1);
    idle(1'b0);
    repeat (4) step();
    $display("youngest-wins lookup checked");

    // Write to r0 is accepted but never queued
    src_addr = 0;
    tar_addr = 0;
    drive(1'b1, 5'd0, 32'd9, 1'b0, '0, '0, 1'b0);
    #1 chk("t6_ready", ld_ready, 1'b1);
    step();
    idle(1'b0);
    step();
    #1 chk("t6_nowrite", reg_write, 1'b0);
    repeat (2) step();
    $display("r0 drop checked");

    // Asynchronous reset with three entries queued and a write in flight
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, AW'(10 + i), 32'h200 + 32'(i), 1'b0, '0, '0, 1'b1);
      step();
    end
    drive(1'b1, 5'd14, 32'h214, 1'b0, '0, '0, 1'b0);
    step();
    step();
    idle(1'b0);
    src_addr = 12;
    #1 check_all();
    #2 rst_n = 1'b0;
    #1;
    chk("t1_reg_write", reg_write, 1'b0);
    chk("t1_full", full, 1'b0);
    chk("t1_ld_ready", ld_ready, 1'b1);
    chk("t1_src_hit", src_hit, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) step();
    $display("mid-queue reset checked");

    // Random traffic on a small address range to exercise collisions
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 9) < 3);
      src_addr = AW'($urandom_range(0, 7));
      tar_addr = AW'($urandom_range(0, 7));
      step();
    end
    idle(1'b0);
    repeat (6) step();
    $display("random traffic checked");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
